// File: rtl/capture_pkg.sv
// ============================================================================
//  capture_pkg
//  Shared types and constants for the sample_capture block.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam int          DEPTH            = 128;
    localparam logic [15:0] AUTOTRIG_TIMEOUT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/sample_capture_if.sv
// ============================================================================
//  sample_capture_if
//  Valid/ready read stream carrying buffered samples out of sample_capture.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sample_capture_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input  rd_ready);
    modport slave  (input  rd_valid, input  rd_data, input  rd_last, output rd_ready);
endinterface

`default_nettype wire

// File: rtl/sample_capture_ram.sv
// ============================================================================
//  sample_ram
//  Simple dual-port buffer RAM: synchronous write, registered 1-cycle read.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_ram #(
    parameter int    DATA_WIDTH = 10,
    parameter int    ADDR_WIDTH = 7,
    parameter string INIT_FILE  = ""
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sample_capture.sv
// ============================================================================
//  sample_capture
//  Triggered ADC capture into a buffer RAM, streamed out over valid/ready.
//  Optional macro SAMPLE_CAPTURE_AUTOTRIG_EN: forced trigger after a timeout.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_capture
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DECIM      = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [DATA_WIDTH-1:0] adc_data,
    input  wire logic [DATA_WIDTH-1:0] trig_level,
    input  wire logic                  arm,
    output logic                       busy,
    output logic                       done,
    sample_capture_if.master           rd
);

    localparam int                    c_CNT_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_CNT_W-1:0]    c_DECIM_LAST = c_CNT_W'(DECIM - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);

    state_t                r_state;
    logic                  r_busy, r_done;
    logic [DATA_WIDTH-1:0] r_s_cur, r_s_prev;
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_rd_all, r_q_vld, r_q_last;
    logic                  r_out_vld, r_out_last, r_skid_vld, r_skid_last;
    logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;

    logic                  w_cross, w_trig, w_we, w_pop, w_issue;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [1:0]            w_stored_next;

    assign w_cross = (r_s_prev < trig_level) && (r_s_cur >= trig_level);

`ifdef SAMPLE_CAPTURE_AUTOTRIG_EN
    logic [15:0] r_to_cnt;
    logic        w_timeout;

    assign w_timeout = (r_to_cnt == AUTOTRIG_TIMEOUT);
    assign w_trig    = w_cross || w_timeout;

    // Held at zero outside ARMED, so every entry starts a fresh timeout.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ARMED)) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_trig = w_cross;
`endif

    assign w_we    = ((r_state == ARMED) && w_trig) ||
                     ((r_state == CAPTURE) && (r_cnt == c_DECIM_LAST));
    assign w_waddr = (r_state == ARMED) ? '0 : r_wptr;

    // Reads are issued only when the word is guaranteed a slot in out/skid
    // on arrival, which keeps rd_ready out of the rd_valid path.
    assign w_pop         = r_out_vld && rd.rd_ready;
    assign w_stored_next = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_q_vld) - 2'(w_pop);
    assign w_issue       = (r_state == READOUT) && !r_rd_all && (w_stored_next <= 2'd1);

    sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  ("")
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_s_cur),
        .i_re    (w_issue),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_s_cur     <= '0;
            r_s_prev    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_rd_all    <= 1'b0;
            r_q_vld     <= 1'b0;
            r_q_last    <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else begin
            r_s_cur  <= adc_data;
            r_s_prev <= r_s_cur;
            r_done   <= 1'b0;
            r_q_vld  <= w_issue;
            r_q_last <= w_issue && (r_rptr == c_LAST_ADDR);

            if (w_issue) begin
                r_rptr <= r_rptr + c_ADDR_ONE;
                if (r_rptr == c_LAST_ADDR) begin
                    r_rd_all <= 1'b1;
                end
            end

            if (w_pop) begin
                if (r_skid_vld) begin
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_skid_vld  <= r_q_vld;
                    r_skid_data <= w_ram_q;
                    r_skid_last <= r_q_last;
                end else if (r_q_vld) begin
                    r_out_data <= w_ram_q;
                    r_out_last <= r_q_last;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (!r_out_vld) begin
                if (r_q_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= w_ram_q;
                    r_out_last <= r_q_last;
                end
            end else if (r_q_vld) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_ram_q;
                r_skid_last <= r_q_last;
            end

            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_state  <= ARMED;
                        r_busy   <= 1'b1;
                        r_rptr   <= '0;
                        r_rd_all <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_trig) begin
                        r_state <= CAPTURE;
                        r_wptr  <= c_ADDR_ONE;
                        r_cnt   <= '0;
                    end
                end
                CAPTURE: begin
                    if (r_cnt == c_DECIM_LAST) begin
                        r_cnt  <= '0;
                        r_wptr <= r_wptr + c_ADDR_ONE;
                        if (r_wptr == c_LAST_ADDR) begin
                            r_state <= READOUT;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                READOUT: begin
                    if (w_pop && r_out_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rd.rd_valid = r_out_vld;
    assign rd.rd_data  = r_out_data;
    assign rd.rd_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_sample_capture.sv
// ============================================================================
//  tb_sample_capture
//  Directed bench for sample_capture: DECIM=1 and DECIM=4 instances side by side.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] adc_data = '0;
    logic [9:0] trig_level = '0;
    logic       arm = 1'b0;
    logic       ready = 1'b1;
    logic       use4 = 1'b0;
    logic       ramp_en = 1'b0;
    logic       busy1, done1, busy4, done4;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sample_capture_if #(.DATA_WIDTH(10)) if1 ();
    sample_capture_if #(.DATA_WIDTH(10)) if4 ();

    assign if1.rd_ready = use4 ? 1'b1 : ready;
    assign if4.rd_ready = use4 ? ready : 1'b1;

    sample_capture #(.DATA_WIDTH(10), .ADDR_WIDTH(7), .DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .adc_data(adc_data), .trig_level(trig_level),
        .arm(arm), .busy(busy1), .done(done1), .rd(if1.master)
    );

    sample_capture #(.DATA_WIDTH(10), .ADDR_WIDTH(7), .DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .adc_data(adc_data), .trig_level(trig_level),
        .arm(arm), .busy(busy4), .done(done4), .rd(if4.master)
    );

    wire       w_valid = use4 ? if4.rd_valid : if1.rd_valid;
    wire [9:0] w_data  = use4 ? if4.rd_data  : if1.rd_data;
    wire       w_last  = use4 ? if4.rd_last  : if1.rd_last;
    wire       w_busy  = use4 ? busy4 : busy1;
    wire       w_done  = use4 ? done4 : done1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (ramp_en) adc_data = adc_data + 10'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0; ramp_en = 1'b0; ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Arms with a ramp starting at zero; the trigger then fires on s_cur == level.
    task automatic arm_ramp(input logic [9:0] lvl);
        adc_data = '0; trig_level = lvl; ramp_en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic collect(input string nm, input int first, input int stp, input int mode,
                           input int abort_at, input bit arm_poke, input int budget);
        int         idx = 0;
        int         cyc = 0;
        int         bubbles = 0;
        bit         started = 0;
        bit         held = 0;
        bit         fin = 0;
        bit         aborted = 0;
        logic [9:0] hd = '0;
        logic       hl = 1'b0;
        logic [9:0] exp_d;
        while (!fin && !aborted && cyc < budget) begin
            if (held) begin
                checks++;
                if (w_valid !== 1'b1 || w_data !== hd || w_last !== hl) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                             nm, w_valid, w_data, w_last, hd, hl);
                end
            end
            if (mode == 0) ready = 1'b1;
            else if (idx < 16) ready = ((cyc & 1) == 0);
            else ready = ($urandom_range(0, 2) != 0);
            arm = arm_poke && w_valid && !ready && (idx == 10);
            if (w_valid) started = 1;
            else if (started) bubbles++;
            if (w_valid && ready) begin
                exp_d = 10'(first + stp * idx);
                checks++;
                if (w_data !== exp_d) begin
                    errors++;
                    $display("FAIL %s data[%0d]: got %0d, required %0d", nm, idx, w_data, exp_d);
                end
                checks++;
                if (w_last !== (idx == 127)) begin
                    errors++;
                    $display("FAIL %s last[%0d]: got %b, required %b", nm, idx, w_last, idx == 127);
                end
                if (w_last) fin = 1;
                idx++;
                held = 0;
            end else begin
                held = w_valid; hd = w_data; hl = w_last;
            end
            tick();
            cyc++;
            if (abort_at > 0 && idx == abort_at && !fin) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checks++;
                if (w_busy !== 1'b0 || w_valid !== 1'b0 || w_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort: busy=%b valid=%b done=%b, required 0 0 0",
                             nm, w_busy, w_valid, w_done);
                end
                aborted = 1;
            end
        end
        arm = 1'b0;
        ready = 1'b1;
        if (aborted) return;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: %0d words after %0d cycles, required 128", nm, idx, cyc);
            return;
        end
        if (w_done !== 1'b1 || w_valid !== 1'b0 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: done=%b valid=%b busy=%b, required 1 0 0", nm, w_done, w_valid, w_busy);
        end
        checks++;
        if (idx !== 128) begin
            errors++;
            $display("FAIL %s count: got %0d, required 128", nm, idx);
        end
        if (mode == 0) begin
            checks++;
            if (bubbles !== 0) begin
                errors++;
                $display("FAIL %s bubbles: got %0d, required 0", nm, bubbles);
            end
        end
        tick(); tick();
        checks++;
        if (w_done !== 1'b0 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b, required 0 0", nm, w_done, w_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b1;
        tick();
        rst = 1'b0; arm = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || if1.rd_valid !== 1'b0 ||
            if1.rd_last !== 1'b0 || if1.rd_data !== 10'd0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b valid=%b last=%b data=%0d busy4=%b, required all 0",
                     busy1, done1, if1.rd_valid, if1.rd_last, if1.rd_data, busy4);
        end
    endtask

    task automatic test_ramp_decim1();
        do_reset(); use4 = 1'b0;
        arm_ramp(10'd100);
        collect("ramp_d1", 100, 1, 0, 0, 0, 3000);
    endtask

    task automatic test_ramp_decim4();
        do_reset(); use4 = 1'b1;
        arm_ramp(10'd100);
        collect("ramp_d4", 100, 4, 0, 0, 0, 3000);
        use4 = 1'b0;
    endtask

    task automatic test_stall();
        do_reset(); use4 = 1'b0;
        arm_ramp(10'd100);
        collect("stall", 100, 1, 1, 0, 0, 3000);
    endtask

    task automatic test_no_trigger();
        do_reset(); use4 = 1'b0;
        adc_data = 10'd50; trig_level = 10'd100; arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (300) tick();
        checks++;
        if (busy1 !== 1'b1 || if1.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_trigger: busy=%b valid=%b, required 1 0", busy1, if1.rd_valid);
        end
`ifdef SAMPLE_CAPTURE_AUTOTRIG_EN
        collect("autotrig", 50, 0, 0, 0, 0, 70000);
`endif
    endtask

    task automatic test_first_armed_cycle();
        do_reset(); use4 = 1'b0;
        adc_data = 10'd0;
        tick();
        trig_level = 10'd100; adc_data = 10'd150; ramp_en = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        collect("first_armed", 150, 1, 0, 0, 0, 3000);
    endtask

    task automatic test_arm_ignored();
        do_reset(); use4 = 1'b0;
        arm_ramp(10'd100);
        repeat (150) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        collect("arm_ignored", 100, 1, 1, 0, 1, 3000);
    endtask

    task automatic test_zero_level();
        do_reset(); use4 = 1'b0;
        arm_ramp(10'd0);
        repeat (1100) tick();
        checks++;
        if (busy1 !== 1'b1 || if1.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_level: busy=%b valid=%b, required 1 0", busy1, if1.rd_valid);
        end
    endtask

    task automatic test_abort_and_rearm();
        do_reset(); use4 = 1'b0;
        arm_ramp(10'd100);
        collect("abort", 100, 1, 0, 60, 0, 3000);
        ramp_en = 1'b0;
        arm_ramp(10'd200);
        collect("rearm", 200, 1, 0, 0, 0, 3000);
    endtask

    initial begin
        test_reset();
        test_ramp_decim1();
        test_ramp_decim4();
        test_stall();
        test_no_trigger();
        test_first_armed_cycle();
        test_arm_ignored();
        test_zero_level();
        test_abort_and_rearm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
